// File: rtl/out_port_arbiter.sv
// out_port_arbiter: round-robin arbiter draining NUM_REQ FWFT FIFOs into one
// valid/ready output register with single-cycle latency and back-to-back throughput.
module out_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 64,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        empty,
  input  logic [NUM_REQ*DATA_W-1:0] in_packet,
  output logic [NUM_REQ-1:0]        read_en,
  input  logic                      ro,
  output logic                      so,
  output logic [DATA_W-1:0]         out_packet,
  output logic [ID_W-1:0]           grant_id,
  output logic [15:0]               pkt_cnt
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t            r_state;
  logic [ID_W-1:0]   r_rr_ptr, r_grant_id, w_win;
  logic [DATA_W-1:0] r_out_packet, w_data;
  logic [15:0]       r_pkt_cnt;
  logic              w_found, w_pop_ok, w_grant, w_xfer;
  assign so         = (r_state == FULL);
  assign w_pop_ok   = !so || ro;
  assign w_xfer     = so && ro;
  assign w_grant    = w_pop_ok && w_found;
  assign read_en    = (reset_n && w_grant) ? NUM_REQ'(1) << w_win : '0;
  assign out_packet = r_out_packet;
  assign grant_id   = r_grant_id;
  assign pkt_cnt    = r_pkt_cnt;
  // Second pass overrides the first, so requesters at or above rr_ptr win over wrapped ones.
  always_comb begin
    w_win = '0;
    w_found = 1'b0;
    w_data = '0;
    for (int i = NUM_REQ-1; i >= 0; i--)
      if (!empty[i]) begin
        w_win = ID_W'(i);
        w_found = 1'b1;
      end
    for (int i = NUM_REQ-1; i >= 0; i--)
      if (!empty[i] && ID_W'(i) >= r_rr_ptr) w_win = ID_W'(i);
    for (int i = 0; i < NUM_REQ; i++)
      if (ID_W'(i) == w_win) w_data = in_packet[i*DATA_W +: DATA_W];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= EMPTY;
      r_rr_ptr     <= '0;
      r_out_packet <= '0;
      r_grant_id   <= '0;
      r_pkt_cnt    <= '0;
    end else begin
      if (w_xfer) r_pkt_cnt <= r_pkt_cnt + {15'd0, r_pkt_cnt != 16'hFFFF};
      if (w_grant) begin
        r_out_packet <= w_data;
        r_grant_id   <= w_win;
        r_rr_ptr     <= (w_win == ID_W'(NUM_REQ-1)) ? '0 : w_win + 1'b1;
        r_state      <= FULL;
      end else if (w_xfer) begin
        r_state <= EMPTY;
      end
    end
  end
endmodule

// File: tb/tb_out_port_arbiter.sv
// tb_out_port_arbiter: FIFO queues feed the arbiter; a transaction-level model
// predicts grants, held packets and the transfer count.
module tb_out_port_arbiter;
  localparam int N = 4, W = 64;
  logic clk = 0, reset_n = 0, ro = 0;
  logic [N-1:0] empty, read_en;
  logic [N*W-1:0] in_packet;
  logic so;
  logic [W-1:0] out_packet;
  logic [1:0] grant_id;
  logic [15:0] pkt_cnt;
  int checks = 0, passed = 0;
  logic [W-1:0] q[N][$];
  bit m_full;
  int m_ptr, m_gid, m_cnt, exp_w;
  logic [W-1:0] m_out;
  logic [N-1:0] exp_rd;

  always #5 clk = ~clk;

  out_port_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk(clk), .reset_n(reset_n), .empty(empty), .in_packet(in_packet), .read_en(read_en),
    .ro(ro), .so(so), .out_packet(out_packet), .grant_id(grant_id), .pkt_cnt(pkt_cnt)
  );

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      empty[i] = (q[i].size() == 0);
      in_packet[i*W +: W] = q[i].size() > 0 ? q[i][0] : '0;
    end
    #1;
    exp_w = -1;
    for (int k = 0; k < N; k++)
      if (exp_w < 0 && q[(m_ptr+k)%N].size() > 0) exp_w = (m_ptr+k)%N;
    if (m_full && !ro) exp_w = -1;
    exp_rd = exp_w < 0 ? '0 : N'(1) << exp_w;
  endtask

  task automatic tick();
    @(posedge clk);
    if (m_full && ro && m_cnt < 65535) m_cnt++;
    if (exp_w >= 0) begin
      m_out = q[exp_w].pop_front();
      m_gid = exp_w;
      m_ptr = (exp_w + 1) % N;
      m_full = 1;
    end else if (m_full && ro) m_full = 0;
    #1 drive();
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) q[i].delete();
    m_full = 0; m_ptr = 0; m_cnt = 0; m_out = '0; m_gid = 0; exp_w = -1;
  endtask

  task automatic do_reset();
    reset_n = 0;
    #1 clear_model();
    @(negedge clk);
    reset_n = 1;
    drive();
  endtask

  task automatic test_reset();
    clear_model();
    q[0].push_back(64'h11); q[2].push_back(64'h22);
    ro = 1;
    drive();
    checks++; if (read_en !== 4'b0000) $display("FAIL reset_read_en got=%b want=0000", read_en); else passed++;
    checks++; if (so !== 1'b0) $display("FAIL reset_so got=%b want=0", so); else passed++;
    checks++; if (out_packet !== 64'h0) $display("FAIL reset_out got=%h want=0", out_packet); else passed++;
    checks++; if (grant_id !== 2'd0) $display("FAIL reset_gid got=%0d want=0", grant_id); else passed++;
    checks++; if (pkt_cnt !== 16'h0) $display("FAIL reset_cnt got=%0d want=0", pkt_cnt); else passed++;
    do_reset();
  endtask

  task automatic test_single();
    q[0].push_back(64'hA5);
    ro = 1;
    drive();
    checks++; if (read_en !== 4'b0001) $display("FAIL single_read_en got=%b want=0001", read_en); else passed++;
    tick();
    checks++; if (so !== 1'b1) $display("FAIL single_so got=%b want=1", so); else passed++;
    checks++; if (out_packet !== 64'hA5) $display("FAIL single_out got=%h want=a5", out_packet); else passed++;
    checks++; if (grant_id !== 2'd0) $display("FAIL single_gid got=%0d want=0", grant_id); else passed++;
    tick();
    checks++; if (pkt_cnt !== 16'd1) $display("FAIL single_cnt got=%0d want=1", pkt_cnt); else passed++;
    checks++; if (so !== 1'b0) $display("FAIL single_so_drop got=%b want=0", so); else passed++;
  endtask

  task automatic test_round_robin();
    int seq[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N; i++) repeat (2) q[i].push_back({$urandom, $urandom});
    ro = 1;
    drive();
    for (int c = 0; c < 5; c++) begin
      checks++; if (read_en !== exp_rd) $display("FAIL rr_read_en c=%0d got=%b want=%b", c, read_en, exp_rd); else passed++;
      tick();
      checks++; if (grant_id !== 2'(seq[c])) $display("FAIL rr_gid c=%0d got=%0d want=%0d", c, grant_id, seq[c]); else passed++;
      checks++; if (so !== 1'b1 || out_packet !== m_out) $display("FAIL rr_out c=%0d so=%b got=%h want=%h", c, so, out_packet, m_out); else passed++;
    end
    tick();
    checks++; if (pkt_cnt !== 16'd5) $display("FAIL rr_cnt got=%0d want=5", pkt_cnt); else passed++;
  endtask

  task automatic test_stall();
    logic [W-1:0] held;
    do_reset();
    held = {$urandom, $urandom};
    q[2].push_back(held);
    ro = 0;
    drive();
    tick();
    for (int c = 0; c < 10; c++) begin
      if (c % 2 == 0) begin q[1].push_back({$urandom, $urandom}); q[3].push_back({$urandom, $urandom}); end
      else begin q[1].delete(); q[0].push_back({$urandom, $urandom}); end
      drive();
      checks++; if (read_en !== 4'b0000) $display("FAIL stall_read_en c=%0d got=%b want=0000", c, read_en); else passed++;
      tick();
      checks++; if (out_packet !== held || grant_id !== 2'd2) $display("FAIL stall_hold c=%0d got=%h/%0d want=%h/2", c, out_packet, grant_id, held); else passed++;
      checks++; if (pkt_cnt !== 16'd0 || so !== 1'b1) $display("FAIL stall_cnt c=%0d cnt=%0d so=%b want=0/1", c, pkt_cnt, so); else passed++;
    end
    ro = 1;
    drive();
    tick();
    checks++; if (pkt_cnt !== 16'd1) $display("FAIL stall_release_cnt got=%0d want=1", pkt_cnt); else passed++;
    checks++; if (grant_id !== 2'(m_gid) || out_packet !== m_out) $display("FAIL stall_release_next got=%0d/%h want=%0d/%h", grant_id, out_packet, m_gid, m_out); else passed++;
  endtask

  task automatic test_ptr();
    do_reset();
    ro = 1;
    q[1].push_back(64'h101);
    drive(); tick(); tick();
    q[1].push_back(64'h102);
    drive(); tick();
    checks++; if (grant_id !== 2'd1 || out_packet !== 64'h102) $display("FAIL ptr_gid1 got=%0d/%h want=1/102", grant_id, out_packet); else passed++;
    q[1].push_back(64'h103); q[3].push_back(64'h301);
    drive();
    checks++; if (read_en !== 4'b1000) $display("FAIL ptr_read_en got=%b want=1000", read_en); else passed++;
    tick();
    checks++; if (grant_id !== 2'd3 || out_packet !== 64'h301) $display("FAIL ptr_gid3 got=%0d/%h want=3/301", grant_id, out_packet); else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < N; i++) q[i].push_back({$urandom, $urandom});
    ro = 1;
    drive(); tick(); tick(); tick();
    ro = 0;
    drive();
    @(posedge clk); #3;
    reset_n = 0;
    #1;
    checks++; if (so !== 1'b0) $display("FAIL async_so got=%b want=0", so); else passed++;
    checks++; if (pkt_cnt !== 16'd0) $display("FAIL async_cnt got=%0d want=0", pkt_cnt); else passed++;
    checks++; if (read_en !== 4'b0000) $display("FAIL async_read_en got=%b want=0000", read_en); else passed++;
    @(posedge clk); #1;
    checks++; if (read_en !== 4'b0000 || so !== 1'b0) $display("FAIL async_hold read_en=%b so=%b want=0000/0", read_en, so); else passed++;
    clear_model();
    @(negedge clk);
    reset_n = 1;
    drive();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (q[i].size() < 3 && $urandom_range(2) == 0) q[i].push_back({$urandom, $urandom});
      ro = ($urandom_range(3) != 0);
      drive();
      checks++; if (read_en !== exp_rd) $display("FAIL rand_read_en c=%0d got=%b want=%b", c, read_en, exp_rd); else passed++;
      checks++; if (so !== m_full) $display("FAIL rand_so c=%0d got=%b want=%b", c, so, m_full); else passed++;
      checks++; if (pkt_cnt !== 16'(m_cnt)) $display("FAIL rand_cnt c=%0d got=%0d want=%0d", c, pkt_cnt, m_cnt); else passed++;
      if (m_full) begin
        checks++; if (out_packet !== m_out || grant_id !== 2'(m_gid)) $display("FAIL rand_out c=%0d got=%h/%0d want=%h/%0d", c, out_packet, grant_id, m_out, m_gid); else passed++;
      end
      tick();
    end
  endtask

  task automatic test_saturate();
    do_reset();
    ro = 1;
    while (m_cnt < 65534) begin
      for (int i = 0; i < N; i++) if (q[i].size() == 0) q[i].push_back({$urandom, $urandom});
      drive();
      tick();
    end
    checks++; if (pkt_cnt !== 16'hFFFE) $display("FAIL sat_pre got=%h want=fffe", pkt_cnt); else passed++;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < N; i++) if (q[i].size() == 0) q[i].push_back({$urandom, $urandom});
      drive();
      tick();
      checks++; if (pkt_cnt !== 16'hFFFF) $display("FAIL sat_cnt c=%0d got=%h want=ffff", c, pkt_cnt); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_ptr();
    test_async_reset();
    test_random();
    test_saturate();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
